// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared states, blink encodings and BCD helpers for the clock time-set block
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } state_t;

  localparam logic [1:0] BLINK_NONE = 2'b00;
  localparam logic [1:0] BLINK_HH   = 2'b01;
  localparam logic [1:0] BLINK_MM   = 2'b10;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MM_MAX = 8'h59;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)
      return 8'h00;
    else if (v[3:0] == 4'h9)
      return {v[7:4] + 4'h1, 4'h0};
    else
      return v + 8'h01;
  endfunction

  // With both nibbles valid, a plain binary compare orders BCD values correctly.
  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] lim);
    if (v[7:4] > 4'h9 || v[3:0] > 4'h9 || v > lim)
      return 8'h00;
    else
      return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, debounce counter and rising-edge pulse for one button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync0;
  logic          r_sync1;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // Any sample matching the current level restarts the run of differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
      r_rise  <= 1'b0;
      if (r_sync1 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync1;
          r_rise  <= r_sync1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/clock_time_set.sv
// rtl/clock_time_set.sv - hour/minute edit FSM with load strobe; AUTO_REPEAT_EN enables inc auto-repeat
module clock_time_set
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  output logic [7:0] set_hh,
  output logic [7:0] set_mm,
  output logic       load,
  output logic       setting,
  output logic [1:0] blink_sel
);

`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic w_unused_mode_level;
  logic w_mode_rise;
  logic w_inc_level;
  logic w_inc_rise;
  logic w_inc_evt;

  state_t        r_state;
  logic [7:0]    r_set_hh;
  logic [7:0]    r_set_mm;
  logic          r_load;
  logic          r_setting;
  logic [1:0]    r_blink;
  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_armed;
  logic          r_rep_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_mode),
    .o_level (w_unused_mode_level),
    .o_rise  (w_mode_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_inc),
    .o_level (w_inc_level),
    .o_rise  (w_inc_rise)
  );

  // Repeat timer runs only while inc is held in an edit state; a mode event restarts it.
  always_ff @(posedge clk) begin
    if (rst || !REP_EN || r_state == RUN || !w_inc_level || w_mode_rise) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
      r_rep_pulse <= 1'b0;
    end else begin
      r_rep_pulse <= 1'b0;
      if (!r_rep_armed && r_rep_cnt == DLY_LAST) begin
        r_rep_pulse <= 1'b1;
        r_rep_armed <= 1'b1;
        r_rep_cnt   <= '0;
      end else if (r_rep_armed && r_rep_cnt == PER_LAST) begin
        r_rep_pulse <= 1'b1;
        r_rep_cnt   <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign w_inc_evt = w_inc_rise | r_rep_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_set_hh  <= 8'h00;
      r_set_mm  <= 8'h00;
      r_load    <= 1'b0;
      r_setting <= 1'b0;
      r_blink   <= BLINK_NONE;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_mode_rise) begin
            r_state   <= SET_HH;
            r_set_hh  <= bcd_sanitize(cur_hh, HH_MAX);
            r_set_mm  <= bcd_sanitize(cur_mm, MM_MAX);
            r_setting <= 1'b1;
            r_blink   <= BLINK_HH;
          end
        end
        SET_HH: begin
          if (w_mode_rise) begin
            r_state <= SET_MM;
            r_blink <= BLINK_MM;
          end else if (w_inc_evt) begin
            r_set_hh <= bcd_inc(r_set_hh, HH_MAX);
          end
        end
        SET_MM: begin
          if (w_mode_rise) begin
            r_state   <= RUN;
            r_load    <= 1'b1;
            r_setting <= 1'b0;
            r_blink   <= BLINK_NONE;
          end else if (w_inc_evt) begin
            r_set_mm <= bcd_inc(r_set_mm, MM_MAX);
          end
        end
        default: begin
          r_state   <= RUN;
          r_setting <= 1'b0;
          r_blink   <= BLINK_NONE;
        end
      endcase
    end
  end

  assign set_hh    = r_set_hh;
  assign set_mm    = r_set_mm;
  assign load      = r_load;
  assign setting   = r_setting;
  assign blink_sel = r_blink;

endmodule

// File: tb/tb_clock_time_set.sv
// tb/tb_clock_time_set.sv - scoreboard bench: each predicted output change is queued and matched by a monitor
module tb_clock_time_set;
  import clock_pkg::*;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] cur_hh = 8'h00;
  logic [7:0] cur_mm = 8'h00;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       load;
  logic       setting;
  logic [1:0] blink_sel;

  always #5 clk = ~clk;

  clock_time_set #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_hh    (cur_hh),
    .cur_mm    (cur_mm),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .load      (load),
    .setting   (setting),
    .blink_sel (blink_sel)
  );

  logic [19:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  bit          first    = 1'b1;
  logic [19:0] prev_s;
  logic [19:0] cur_s;
  logic [19:0] exp_s;

  task automatic expect_out(input bit ld, input bit st, input logic [1:0] bl,
                            input logic [7:0] h, input logic [7:0] m);
    exp_q.push_back({ld, st, bl, h, m});
  endtask

  // Every change of {load, setting, blink_sel, set_hh, set_mm} must have been predicted.
  always @(negedge clk) begin
    if (mon_en) begin
      cur_s = {load, setting, blink_sel, set_hh, set_mm};
      if (first || cur_s !== prev_s) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change got=%h required=none", cur_s);
        end else begin
          exp_s = exp_q.pop_front();
          if (cur_s === exp_s) n_pass++;
          else $display("FAIL output_change got=%h required=%h", cur_s, exp_s);
        end
        first = 1'b0;
      end
      prev_s = cur_s;
    end
  end

  task automatic press(input bit m, input bit i, input int hold);
    @(posedge clk); #1;
    btn_mode = m;
    btn_inc  = i;
    repeat (hold) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (DB + 6) @(posedge clk);
  endtask

  logic [7:0] mm_end;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    expect_out(0, 0, BLINK_NONE, 8'h00, 8'h00);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // 22:58 edit with both fields wrapping, then commit
    cur_hh = 8'h22; cur_mm = 8'h58;
    press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_HH, 8'h22, 8'h58); press(1, 0, DB + 2);
    expect_out(0, 1, BLINK_HH, 8'h23, 8'h58); press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_HH, 8'h00, 8'h58); press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h00, 8'h58); press(1, 0, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h00, 8'h59); press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h00, 8'h00); press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h00, 8'h01); press(0, 1, DB + 2);
    expect_out(1, 0, BLINK_NONE, 8'h00, 8'h01);
    expect_out(0, 0, BLINK_NONE, 8'h00, 8'h01);
    press(1, 0, DB + 2);

    // invalid hours captured as zero, glitch filtering, simultaneous mode+inc
    cur_hh = 8'h2A; cur_mm = 8'h37;
    expect_out(0, 1, BLINK_HH, 8'h00, 8'h37); press(1, 0, DB + 2);
    press(0, 1, DB - 1);
    expect_out(0, 1, BLINK_HH, 8'h01, 8'h37); press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h01, 8'h37); press(1, 1, DB + 2);

    // reset mid-edit aborts without a load
    expect_out(0, 0, BLINK_NONE, 8'h00, 8'h00);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // long inc hold in SET_MM
    cur_hh = 8'h19; cur_mm = 8'h58;
    expect_out(0, 1, BLINK_HH, 8'h19, 8'h58); press(1, 0, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h19, 8'h58); press(1, 0, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h19, 8'h59);
`ifdef AUTO_REPEAT_EN
    expect_out(0, 1, BLINK_MM, 8'h19, 8'h00);
    expect_out(0, 1, BLINK_MM, 8'h19, 8'h01);
    expect_out(0, 1, BLINK_MM, 8'h19, 8'h02);
    expect_out(0, 1, BLINK_MM, 8'h19, 8'h03);
    mm_end = 8'h03;
`else
    mm_end = 8'h59;
`endif
    press(0, 1, RD + 3 * RP + 2);
    expect_out(1, 0, BLINK_NONE, 8'h19, mm_end);
    expect_out(0, 0, BLINK_NONE, 8'h19, mm_end);
    press(1, 0, DB + 2);

    // out-of-range minutes captured as zero, hour wrap from 23
    cur_hh = 8'h23; cur_mm = 8'h60;
    expect_out(0, 1, BLINK_HH, 8'h23, 8'h00); press(1, 0, DB + 2);
    expect_out(0, 1, BLINK_HH, 8'h00, 8'h00); press(0, 1, DB + 2);
    expect_out(0, 1, BLINK_MM, 8'h00, 8'h00); press(1, 0, DB + 2);
    expect_out(1, 0, BLINK_NONE, 8'h00, 8'h00);
    expect_out(0, 0, BLINK_NONE, 8'h00, 8'h00);
    press(1, 0, DB + 2);
    press(0, 1, DB + 2);

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    while (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL missing_change got=none required=%h", exp_q.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_time_set.md
# clock_time_set

Time-set controller for the digital clock: the write side of the clock core's time registers. It debounces two raw push-buttons and steps an FSM through hour and minute editing. When editing finishes it issues a single load strobe that writes BCD hours/minutes into the clock counters. While editing, it pauses the core and drives the display blink select.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical synchronized samples required to accept a new button level (≥2)
- REPEAT_DELAY, 64: cycles of held inc before the first auto-repeat (AUTO_REPEAT_EN only)
- REPEAT_PERIOD, 16: cycles between subsequent auto-repeats (AUTO_REPEAT_EN only)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- btn_mode  in  1  raw mode button, asynchronous, active-high
- btn_inc  in  1  raw increment button, asynchronous, active-high
- cur_hh  in  8  current hours from clock core, BCD 00–23
- cur_mm  in  8  current minutes from clock core, BCD 00–59
- set_hh  out  8  edited hours, BCD
- set_mm  out  8  edited minutes, BCD
- load  out  1  one-cycle strobe: core loads set_hh/set_mm and clears seconds
- setting  out  1  high in SET_HH/SET_MM; core holds its counters
- blink_sel  out  2  00 none, 01 hours, 10 minutes

## Operation
- Each button path: 2-FF synchronizer, then debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive samples that differ from the current level. A press event is a one-cycle pulse on the debounced rising edge.
- FSM states: RUN, SET_HH, SET_MM.
  - RUN + mode event → SET_HH. In the same edge, capture cur_hh → set_hh and cur_mm → set_mm. A captured field is replaced with 8'h00 if it is invalid BCD (nibble >9) or out of range (hh >23, mm >59).
  - SET_HH + mode → SET_MM.
  - SET_MM + mode → RUN, with load registered high for exactly the next cycle.
- Inc event in SET_HH: set_hh BCD+1, wraps 23→00. In SET_MM: set_mm BCD+1, wraps 59→00, no carry into hours. Ignored in RUN.
- A mode event and an inc event in the same cycle: mode wins and inc is discarded.
- setting = (state != RUN). blink_sel = 01 in SET_HH, 10 in SET_MM, else 00.
- Reset, at any time including mid-edit: state RUN; set_hh, set_mm = 8'h00; load = 0, setting = 0, blink_sel = 00; synchronizers, debounced levels and counters = 0. No load is issued for an edit aborted by reset.

## Timing
- Raw press to press event: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- State, set_* and blink_sel update on the edge after the event.
- load rises the cycle after the final mode event. It is high for exactly 1 cycle. set_hh/set_mm are stable for that cycle and thereafter until the next edit.
- setting falls in the same cycle load rises.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

## Configuration
- AUTO_REPEAT_EN defined: while the inc debounced level stays high in SET_HH/SET_MM, an extra inc event fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles. The repeat counter clears on release, on a state change, and on reset.
- Not defined: exactly one inc event per press. The REPEAT_* parameters are unused.

## Structure
- Package clock_pkg holds:
  - the state typedef enum {RUN, SET_HH, SET_MM}
  - blink_sel encodings BLINK_NONE/BLINK_HH/BLINK_MM
  - constants HH_MAX = 8'h23, MM_MAX = 8'h59
- Sub-module btn_debounce (synchronizer, counter, rising-edge pulse) is instantiated twice, parameterized by DEBOUNCE_CYCLES.

## Test plan
- Reset mid-SET_MM with set_mm = 8'h37 → state RUN, all outputs zero, no load pulse.
- cur = 22:58, mode press, inc ×2, mode, inc ×3, mode → load pulse for 1 cycle with set_hh = 8'h00, set_mm = 8'h01.
- btn_inc glitch lasting DEBOUNCE_CYCLES−1 in SET_HH → set_hh unchanged. A glitch lasting DEBOUNCE_CYCLES+2 → +1.
- Mode and inc debounced in the same cycle while in SET_HH → SET_MM entered, set_hh unchanged.
- cur_hh = 8'h2A on capture → set_hh = 8'h00. Inc presses in RUN → no output change.
- AUTO_REPEAT_EN, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 8, REPEAT_PERIOD = 4: hold inc 8+4·3 cycles past the debounce in SET_MM from 8'h58 → 1 + 1 + 3 increments, set_mm = 8'h03.
